// File: rtl/rr_arb_mux_pkg.sv
// Shared constants for the registered round-robin / fixed-select channel mux.
package rr_arb_mux_pkg;

  localparam logic MODE_FIXED    = 1'b0;
  localparam logic MODE_RR       = 1'b1;
  localparam int   DEFAULT_WIDTH = 32;

  // Advance a channel index by one, wrapping at n (n need not be a power of two)
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 32'sd1) ? 32'sd0 : idx + 32'sd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: lowest requester at or above ptr,
// otherwise lowest requester overall (the wrapped part of the scan).
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [SELW-1:0] i_ptr,
  output logic [SELW-1:0] o_grant,
  output logic            o_grant_valid
);

  logic [SELW-1:0] w_grant_hi;
  logic [SELW-1:0] w_grant_lo;
  logic            w_hit_hi;

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    w_grant_hi = '0;
    w_grant_lo = '0;
    w_hit_hi   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      w_grant_lo = i_req[i] ? SELW'(i) : w_grant_lo;
      w_grant_hi = (i_req[i] && (SELW'(i) >= i_ptr)) ? SELW'(i) : w_grant_hi;
      w_hit_hi   = w_hit_hi | (i_req[i] && (SELW'(i) >= i_ptr));
    end
  end

  assign o_grant       = w_hit_hi ? w_grant_hi : w_grant_lo;
  assign o_grant_valid = |i_req;

endmodule

// File: rtl/rr_arb_mux.sv
// Registered N-to-1 mux with valid/ready on every channel; channel chosen by
// an external select (fixed mode) or by a rotating-priority arbiter.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_src
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SELW-1:0]  r_out_src;
  logic [SELW-1:0]  r_rr_ptr;

  logic             w_load_en;
  logic [SELW-1:0]  w_rr_grant;
  logic             w_rr_valid;
  logic             w_fix_valid;
  logic [SELW-1:0]  w_grant;
  logic             w_grant_valid;
  logic [WIDTH-1:0] w_word;
  logic             w_xfer;
  logic [SELW-1:0]  w_ptr_next;

  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .i_req         (in_valid),
    .i_ptr         (r_rr_ptr),
    .o_grant       (w_rr_grant),
    .o_grant_valid (w_rr_valid)
  );

  // The register can take a new word whenever it is empty or draining
  assign w_load_en  = !r_out_valid || out_ready;
  assign w_xfer     = !rst && w_load_en && w_grant_valid;
  assign w_ptr_next = SELW'(wrap_inc(int'(w_grant), N));

  // Fixed-mode request: a select outside 0..N-1 matches no channel
  always_comb begin
    w_fix_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_fix_valid = (SELW'(i) == sel) ? in_valid[i] : w_fix_valid;
    end
  end

  // Mode mux between external select and arbiter result
  always_comb begin
    case (mode)
      MODE_FIXED: begin
        w_grant       = sel;
        w_grant_valid = w_fix_valid;
      end
      MODE_RR: begin
        w_grant       = w_rr_grant;
        w_grant_valid = w_rr_valid;
      end
      default: begin
        w_grant       = '0;
        w_grant_valid = 1'b0;
      end
    endcase
  end

  // Granted word and one-hot ready back to the producers
  always_comb begin
    w_word   = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      w_word      = (w_grant == SELW'(i)) ? in_data[i*WIDTH +: WIDTH] : w_word;
      in_ready[i] = w_xfer && (w_grant == SELW'(i));
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_load_en) begin
        r_out_valid <= w_grant_valid;
        if (w_grant_valid) begin
          r_out_data <= w_word;
          r_out_src  <= w_grant;
        end
      end
      if (w_xfer && (mode == MODE_RR)) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised, registered N-to-1 multiplexer with valid/ready handshakes on every input channel and on the output.
- Two selection modes:
  - Fixed mode: an external select chooses the channel, as the combinational 4-1 datapath mux does.
  - Round-robin mode: arbitration across all requesting channels.
- Sits between multiple datapath producers (register-file read ports, ALU result, memory return, immediate path) and a single consumer stage.
- Adds one pipeline register and backpressure support.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- N, 4, number of input channels (2..16, need not be a power of two).
- SELW, 2, width of sel and out_src; must satisfy 2**SELW >= N.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  channel i has a word
- in_ready  out  N  channel i word is accepted this cycle
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SELW  channel index used when mode = 0
- out_data  out  WIDTH  registered output word
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts the word this cycle
- out_src  out  SELW  index of the channel that supplied out_data

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: out_valid = 0, out_data = 0, out_src = 0, rr_ptr = 0. in_ready = 0 in every cycle where rst = 1.
- Load enable: load_en = !out_valid || out_ready. The output register accepts a new word even in a cycle where it drains one, giving full throughput of 1 word/cycle.
- Grant, mode 0:
  - grant_valid = (sel < N) && in_valid[sel]; grant = sel.
  - sel >= N never grants.
- Grant, mode 1:
  - Scan from rr_ptr upward, wrapping modulo N. grant = first i with in_valid[i] = 1.
  - grant_valid = |in_valid.
- Handshake:
  - in_ready[i] = !rst && load_en && grant_valid && (grant == i). At most one bit of in_ready is set.
  - A transfer on channel i occurs when in_valid[i] && in_ready[i].
- Register update at posedge, when not in reset:
  - If load_en: out_valid <= grant_valid.
  - If load_en && grant_valid: out_data <= selected word, out_src <= grant.
  - If !load_en: all output registers hold.
  - out_data and out_src also hold when out_valid falls to 0.
- Round-robin pointer:
  - On a transfer in mode 1: rr_ptr <= (grant == N-1) ? 0 : grant + 1.
  - rr_ptr is unchanged in mode 0 and on cycles with no transfer.
- Latency: a word accepted at edge k appears on out_data/out_valid after edge k, i.e. 1 cycle.
- Stability: while out_valid && !out_ready, out_data and out_src are stable. Input channels see in_ready = 0.
- Producer rule: a producer must hold in_valid/in_data until its handshake completes. The block does not require this for correctness, only for no data loss.
- Mode or sel change: takes effect combinationally on the next grant. A word already held in the output register is unaffected.
- Reset mid-operation: any held word is discarded, out_valid = 0 in the next cycle, rr_ptr returns to 0.
- Fairness: in mode 1 with all N channels continuously valid and out_ready = 1, the grant sequence is 0, 1, ..., N-1, 0, ... No channel waits more than N-1 transfers.

Decomposition:
- Shared package/header:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1.
  - Default WIDTH = 32 constant, shared with the CPU datapath.
- Natural sub-module: rr_arbiter.
  - Inputs: req[N], ptr.
  - Outputs: grant index, grant_valid.
  - Purely combinational.
- The top level holds the output register, rr_ptr, mode muxing and handshake logic.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, in_ready = 0; after release, first grant in mode 1 goes to ch0.
- Fixed mode: mode = 0, sel = 2, in_data ch2 = 0xDEADBEEF, all valid, out_ready = 1 -> in_ready = 4'b0100; next cycle out_data = 0xDEADBEEF, out_src = 2.
- Round-robin: mode = 1, all 4 valid continuously with distinct data 0x10..0x13, out_ready = 1 -> out_src sequence 0, 1, 2, 3, 0 on consecutive cycles, one word per cycle.
- Backpressure: out_valid = 1 holding 0x11, out_ready = 0 for 3 cycles -> out_data stays 0x11, in_ready = 0; raise out_ready -> 0x11 drains and the next grant loads in the same cycle.
- Sparse and wrap: mode = 1, rr_ptr = 3, only ch1 valid -> grant = 1, rr_ptr becomes 2. Then with only ch0 and ch3 valid -> grant = 3, then 0.
- Invalid sel and mid-reset: N = 3, mode = 0, sel = 3 -> no in_ready, out_valid = 0. A separate sequence asserts rst while out_valid = 1 with out_ready = 0 -> out_valid = 0 the next cycle and rr_ptr = 0.
